// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
//   Resolves conditional branches in the ID stage and keeps a 2-bit saturating
//   branch history table (BHT). The IF stage reads the table combinationally.
//
//   Ports:
//     clk, rst             core clock and synchronous active-high reset
//     stall                ID is held. While it is high nothing resolves or updates.
//     IF_pc / IF_pred_taken  fetch PC and the prediction made for it
//     ID_*                 ID-stage instruction fields, register data and carried prediction
//     EX/ME/WB_result      forwarding sources
//     forward_c/forward_d  operand selects (00 regfile, 01 WB, 10 ME, 11 EX)
//     br_taken, mispredict, redirect_pc  combinational resolution outputs
//
//   Optional feature: define BRPRED_STATS_EN to add the stat_branches and
//   stat_mispred counters. Both are 32 bits wide and wrap around.
//
//   BHT counter states:
//     state | meaning
//     00    | strong not-taken
//     01    | weak not-taken (reset value)
//     10    | weak taken
//     11    | strong taken
module branch_resolve_unit #(
  parameter int XLEN      = 32,
  parameter int BHT_IDX_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic [XLEN-1:0] IF_pc,
  output logic            IF_pred_taken,
  input  logic            ID_valid,
  input  logic            ID_is_branch,
  input  logic [2:0]      ID_funct3,
  input  logic [XLEN-1:0] ID_pc,
  input  logic [XLEN-1:0] ID_imm,
  input  logic            ID_pred_taken,
  input  logic [XLEN-1:0] ID_rs1_data,
  input  logic [XLEN-1:0] ID_rs2_data,
  input  logic [XLEN-1:0] EX_result,
  input  logic [XLEN-1:0] ME_result,
  input  logic [XLEN-1:0] WB_result,
  input  logic [1:0]      forward_c,
  input  logic [1:0]      forward_d,
  output logic            br_taken,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc
`ifdef BRPRED_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispred
`endif
);

  localparam int BHT_N = 1 << BHT_IDX_W;

  localparam logic [1:0] BHT_SNT = 2'b00;
  localparam logic [1:0] BHT_WNT = 2'b01;
  localparam logic [1:0] BHT_ST  = 2'b11;

  logic [XLEN-1:0]      op_a;
  logic [XLEN-1:0]      op_b;
  logic                 cond;
  logic                 cond_legal;
  logic                 resolve_en;
  logic [BHT_IDX_W-1:0] if_idx;
  logic [BHT_IDX_W-1:0] id_idx;
  logic [1:0]           bht_q [BHT_N];
  logic [1:0]           bht_d [BHT_N];

  always_comb begin
    op_a = ID_rs1_data;
    case (forward_c)
      2'b01:   op_a = WB_result;
      2'b10:   op_a = ME_result;
      2'b11:   op_a = EX_result;
      default: op_a = ID_rs1_data;
    endcase
  end

  always_comb begin
    op_b = ID_rs2_data;
    case (forward_d)
      2'b01:   op_b = WB_result;
      2'b10:   op_b = ME_result;
      2'b11:   op_b = EX_result;
      default: op_b = ID_rs2_data;
    endcase
  end

  always_comb begin
    cond       = 1'b0;
    cond_legal = 1'b1;
    case (ID_funct3)
      3'b000:  cond = (op_a == op_b);
      3'b001:  cond = (op_a != op_b);
      3'b100:  cond = ($signed(op_a) <  $signed(op_b));
      3'b101:  cond = ($signed(op_a) >= $signed(op_b));
      3'b110:  cond = (op_a <  op_b);
      3'b111:  cond = (op_a >= op_b);
      default: cond_legal = 1'b0;
    endcase
  end

  assign resolve_en  = ID_valid & ID_is_branch & ~stall;
  assign br_taken    = resolve_en & cond;
  assign mispredict  = resolve_en & (br_taken != ID_pred_taken);
  assign redirect_pc = br_taken ? (ID_pc + ID_imm) : (ID_pc + XLEN'(4));

  assign if_idx = IF_pc[BHT_IDX_W+1:2];
  assign id_idx = ID_pc[BHT_IDX_W+1:2];

  // The IF lookup reads the registered table with no bypass. An update to the
  // same index in this cycle becomes visible to IF on the next cycle.
  assign IF_pred_taken = bht_q[if_idx][1];

  logic unused_if_pc_bits;
  assign unused_if_pc_bits = ^{IF_pc[XLEN-1:BHT_IDX_W+2], IF_pc[1:0]};

  always_comb begin
    for (int i = 0; i < BHT_N; i++) begin
      bht_d[i] = bht_q[i];
    end
    if (resolve_en && cond_legal) begin
      if (br_taken) begin
        bht_d[id_idx] = (bht_q[id_idx] == BHT_ST) ? BHT_ST : bht_q[id_idx] + 2'd1;
      end else begin
        bht_d[id_idx] = (bht_q[id_idx] == BHT_SNT) ? BHT_SNT : bht_q[id_idx] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < BHT_N; i++) begin
      if (rst) begin
        bht_q[i] <= BHT_WNT;
      end else begin
        bht_q[i] <= bht_d[i];
      end
    end
  end

`ifdef BRPRED_STATS_EN
  logic [31:0] stat_branches_q;
  logic [31:0] stat_branches_d;
  logic [31:0] stat_mispred_q;
  logic [31:0] stat_mispred_d;

  // Illegal funct3 encodings are still counted because resolve_en does not
  // depend on the encoding.
  always_comb begin
    stat_branches_d = stat_branches_q + {31'd0, resolve_en};
    stat_mispred_d  = stat_mispred_q + {31'd0, mispredict};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches_q <= 32'd0;
      stat_mispred_q  <= 32'd0;
    end else begin
      stat_branches_q <= stat_branches_d;
      stat_mispred_q  <= stat_mispred_d;
    end
  end

  assign stat_branches = stat_branches_q;
  assign stat_mispred  = stat_mispred_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [31:0] IF_pc;
  logic        IF_pred_taken;
  logic        ID_valid;
  logic        ID_is_branch;
  logic [2:0]  ID_funct3;
  logic [31:0] ID_pc;
  logic [31:0] ID_imm;
  logic        ID_pred_taken;
  logic [31:0] ID_rs1_data;
  logic [31:0] ID_rs2_data;
  logic [31:0] EX_result;
  logic [31:0] ME_result;
  logic [31:0] WB_result;
  logic [1:0]  forward_c;
  logic [1:0]  forward_d;
  logic        br_taken;
  logic        mispredict;
  logic [31:0] redirect_pc;
`ifdef BRPRED_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispred;
`endif

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  // Reference state: one saturating counter value (0..3) per table entry.
  int          bht_m [16];
  int unsigned nbr_m = 0;
  int unsigned nmis_m = 0;

  always #5 clk = ~clk;

  branch_resolve_unit dut (
    .clk(clk), .rst(rst), .stall(stall),
    .IF_pc(IF_pc), .IF_pred_taken(IF_pred_taken),
    .ID_valid(ID_valid), .ID_is_branch(ID_is_branch), .ID_funct3(ID_funct3),
    .ID_pc(ID_pc), .ID_imm(ID_imm), .ID_pred_taken(ID_pred_taken),
    .ID_rs1_data(ID_rs1_data), .ID_rs2_data(ID_rs2_data),
    .EX_result(EX_result), .ME_result(ME_result), .WB_result(WB_result),
    .forward_c(forward_c), .forward_d(forward_d),
    .br_taken(br_taken), .mispredict(mispredict), .redirect_pc(redirect_pc)
`ifdef BRPRED_STATS_EN
    , .stat_branches(stat_branches), .stat_mispred(stat_mispred)
`endif
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rf,
                                       input logic [31:0] wb, input logic [31:0] me,
                                       input logic [31:0] ex);
    logic [31:0] src [4];
    src = '{rf, wb, me, ex};
    return src[sel];
  endfunction

  function automatic bit legal_f3(input logic [2:0] f3);
    return !(f3 == 3'b010 || f3 == 3'b011);
  endfunction

  function automatic bit cond_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (f3)
      3'b000:  return ua == ub;
      3'b001:  return ua != ub;
      3'b100:  return sa < sb;
      3'b101:  return sa >= sb;
      3'b110:  return ua < ub;
      3'b111:  return ua >= ub;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit resolve_m();
    return ID_valid && ID_is_branch && !stall;
  endfunction

  function automatic bit taken_m();
    logic [31:0] a, b;
    a = pick(forward_c, ID_rs1_data, WB_result, ME_result, EX_result);
    b = pick(forward_d, ID_rs2_data, WB_result, ME_result, EX_result);
    return resolve_m() && cond_m(ID_funct3, a, b);
  endfunction

  // The compare process checks every cycle once the reference state is defined.
  always @(negedge clk) begin
    if (chk_en) begin
      bit t;
      longint unsigned tgt;
      t = taken_m();
      tgt = t ? (longint'({32'd0, ID_pc}) + longint'({32'd0, ID_imm})) % 64'h1_0000_0000
              : (longint'({32'd0, ID_pc}) + 4) % 64'h1_0000_0000;
      chk("m_br_taken", {31'd0, br_taken}, {31'd0, t});
      chk("m_mispredict", {31'd0, mispredict}, {31'd0, resolve_m() && (t != ID_pred_taken)});
      chk("m_redirect_pc", redirect_pc, tgt[31:0]);
      chk("m_if_pred", {31'd0, IF_pred_taken}, {31'd0, bht_m[(IF_pc / 4) % 16] >= 2});
`ifdef BRPRED_STATS_EN
      chk("m_stat_branches", stat_branches, nbr_m);
      chk("m_stat_mispred", stat_mispred, nmis_m);
`endif
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      foreach (bht_m[i]) bht_m[i] = 1;
      nbr_m  = 0;
      nmis_m = 0;
    end else begin
      bit t;
      int k;
      t = taken_m();
      k = (ID_pc / 4) % 16;
      if (resolve_m()) begin
        nbr_m++;
        if (t != ID_pred_taken) nmis_m++;
        if (legal_f3(ID_funct3)) begin
          if (t) bht_m[k] = (bht_m[k] == 3) ? 3 : bht_m[k] + 1;
          else   bht_m[k] = (bht_m[k] == 0) ? 0 : bht_m[k] - 1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ID_valid = 0; ID_is_branch = 0; ID_funct3 = 0; ID_pc = 0; ID_imm = 0;
    ID_pred_taken = 0; ID_rs1_data = 0; ID_rs2_data = 0; EX_result = 0;
    ME_result = 0; WB_result = 0; forward_c = 0; forward_d = 0; stall = 0;
  endtask

  task automatic set_br(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                        input logic pred, input logic [31:0] a, input logic [31:0] b);
    idle();
    ID_valid = 1; ID_is_branch = 1; ID_funct3 = f3; ID_pc = pc; ID_imm = imm;
    ID_pred_taken = pred; ID_rs1_data = a; ID_rs2_data = b;
  endtask

  initial begin
    logic [31:0] pool [6];
    rst = 1; IF_pc = 0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    chk_en = 1;

    // Taken BEQ predicted not-taken; the entry moves to weak-taken.
    IF_pc = 32'h40;
    set_br(3'b000, 32'h40, 32'h10, 0, 5, 5);
    @(negedge clk);
    chk("beq_pred0", {31'd0, IF_pred_taken}, 0);
    chk("beq_taken", {31'd0, br_taken}, 1);
    chk("beq_misp", {31'd0, mispredict}, 1);
    chk("beq_redir", redirect_pc, 32'h50);
    step(); idle();
    @(negedge clk);
    chk("beq_pred_next", {31'd0, IF_pred_taken}, 1);

    // Forwarded operands: EX result on op_a and ME result on op_b.
    step();
    set_br(3'b001, 32'h100, 32'h20, 1, 7, 9);
    EX_result = 3; ME_result = 3; forward_c = 2'b11; forward_d = 2'b10;
    @(negedge clk);
    chk("fwd_taken", {31'd0, br_taken}, 0);
    chk("fwd_misp", {31'd0, mispredict}, 1);
    chk("fwd_redir", redirect_pc, 32'h104);

    // Saturation at index 2: taken four times, then not-taken twice.
    IF_pc = 32'h88;
    for (int i = 0; i < 4; i++) begin
      step();
      set_br(3'b110, 32'h88, 32'h8, 0, 1, 32'hFFFF_FFFF);
      @(negedge clk);
      chk($sformatf("sat_up_pred%0d", i), {31'd0, IF_pred_taken}, (i == 0) ? 0 : 1);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      set_br(3'b110, 32'h88, 32'h8, 1, 5, 1);
      @(negedge clk);
      chk($sformatf("sat_dn_pred%0d", i), {31'd0, IF_pred_taken}, 1);
    end
    step(); idle();
    @(negedge clk);
    chk("sat_final_pred", {31'd0, IF_pred_taken}, 0);

    // Signed and unsigned comparisons of 0xFFFFFFFF against 1.
    begin
      logic [2:0] f3s [4];
      logic       exp [4];
      f3s = '{3'b100, 3'b110, 3'b101, 3'b111};
      exp = '{1'b1, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 4; i++) begin
        step();
        set_br(f3s[i], 32'h200, 32'h40, 0, 32'hFFFF_FFFF, 1);
        @(negedge clk);
        chk($sformatf("sgn_f3_%0d", f3s[i]), {31'd0, br_taken}, {31'd0, exp[i]});
      end
    end

    // A taken BEQ held for three stalled cycles, then resolved once.
    IF_pc = 32'h94;
    for (int i = 0; i < 4; i++) begin
      step();
      set_br(3'b000, 32'h94, 32'h100, 0, 9, 9);
      stall = (i < 3);
      @(negedge clk);
      chk($sformatf("stall_misp%0d", i), {31'd0, mispredict}, (i < 3) ? 0 : 1);
      chk($sformatf("stall_pred%0d", i), {31'd0, IF_pred_taken}, 0);
    end
    step(); idle();
    @(negedge clk);
    chk("stall_pred_after", {31'd0, IF_pred_taken}, 1);

    // Update and lookup hit the same index in the same cycle.
    step();
    IF_pc = 32'h0C;
    set_br(3'b000, 32'h0C, 32'h4, 0, 1, 1);
    @(negedge clk);
    chk("coll_pred_same", {31'd0, IF_pred_taken}, 0);
    step(); idle();
    @(negedge clk);
    chk("coll_pred_next", {31'd0, IF_pred_taken}, 1);
    step();
    set_br(3'b000, 32'h0C, 32'h4, 0, 1, 1);
    rst = 1;
    @(negedge clk);
    chk("rst_comb_taken", {31'd0, br_taken}, 1);
    step(); rst = 0; idle();
    @(negedge clk);
    chk("rst_pred", {31'd0, IF_pred_taken}, 0);

    // An illegal funct3 must leave a weak-taken entry unchanged.
    step();
    IF_pc = 32'h14;
    set_br(3'b000, 32'h14, 32'h40, 0, 2, 2);
    step();
    set_br(3'b010, 32'h14, 32'h40, 1, 5, 5);
    @(negedge clk);
    chk("ill_taken", {31'd0, br_taken}, 0);
    chk("ill_misp", {31'd0, mispredict}, 1);
    chk("ill_redir", redirect_pc, 32'h18);
    step(); idle();
    @(negedge clk);
    chk("ill_pred_kept", {31'd0, IF_pred_taken}, 1);

    // Randomized traffic, checked every cycle by the compare process.
    pool = '{32'd0, 32'd1, 32'd5, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    for (int n = 0; n < 3000; n++) begin
      step();
      rst           = ($urandom_range(0, 99) < 2);
      stall         = ($urandom_range(0, 99) < 20);
      ID_valid      = ($urandom_range(0, 99) < 85);
      ID_is_branch  = ($urandom_range(0, 99) < 80);
      ID_funct3     = 3'($urandom_range(0, 7));
      ID_pred_taken = 1'($urandom_range(0, 1));
      ID_pc         = ($urandom_range(0, 3) == 0) ? $urandom : {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      ID_imm        = ($urandom_range(0, 3) == 0) ? $urandom : 32'($signed(12'($urandom)));
      IF_pc         = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      ID_rs1_data   = ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 5)] : $urandom;
      ID_rs2_data   = ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 5)] : $urandom;
      EX_result     = pool[$urandom_range(0, 5)];
      ME_result     = pool[$urandom_range(0, 5)];
      WB_result     = pool[$urandom_range(0, 5)];
      forward_c     = 2'($urandom_range(0, 3));
      forward_d     = 2'($urandom_range(0, 3));
    end
    step();
    rst = 0; idle();
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- ID-stage branch resolver and dynamic predictor for the 5-stage RV32I core with branch prediction.
- Consumes the ID-operand forwarding selects (forward_c/forward_d) from the forwarding unit and muxes the rs1/rs2 compare operands.
- Resolves conditional branches in ID, and maintains a 2-bit saturating branch history table (BHT) that is read at IF.
- Produces the IF prediction, a mispredict/flush pulse and the redirect PC.

Parameters:
- XLEN, 32, datapath and PC width.
- BHT_IDX_W, 4, log2 of BHT entries (default 16). Index is pc[BHT_IDX_W+1:2].

Ports:
- clk  in  1  core clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  ID held (load-use / memory stall); blocks update and resolution
- IF_pc  in  XLEN  fetch PC for prediction lookup
- IF_pred_taken  out  1  prediction for IF_pc
- ID_valid  in  1  ID holds a real instruction (not a bubble)
- ID_is_branch  in  1  ID instruction is B-type
- ID_funct3  in  3  branch condition
- ID_pc  in  XLEN  PC of the ID instruction
- ID_imm  in  XLEN  sign-extended B-immediate
- ID_pred_taken  in  1  prediction carried through IF/ID
- ID_rs1_data, ID_rs2_data  in  XLEN  register-file read data
- EX_result, ME_result, WB_result  in  XLEN  forwarding sources
- forward_c, forward_d  in  2  operand selects: 00 regfile, 01 WB, 10 ME, 11 EX
- br_taken  out  1  resolved outcome
- mispredict  out  1  flush IF/ID and redirect
- redirect_pc  out  XLEN  correct next PC

Behaviour:
- Operand mux is combinational: op_a selects by forward_c and op_b by forward_d, over {regfile, WB, ME, EX}.
- Conditions:
  - 000 BEQ: equal
  - 001 BNE: not equal
  - 100 BLT: signed less-than
  - 101 BGE: signed greater-or-equal
  - 110 BLTU: unsigned less-than
  - 111 BGEU: unsigned greater-or-equal
  - 010/011 are illegal: br_taken=0.
- resolve_en = ID_valid & ID_is_branch & !stall.
  - br_taken = resolve_en & cond.
  - mispredict = resolve_en & (br_taken != ID_pred_taken).
  - Illegal funct3 with ID_pred_taken=1 therefore mispredicts to fall-through.
- redirect_pc = br_taken ? ID_pc+ID_imm : ID_pc+4. Arithmetic is modulo 2^XLEN; wrap is allowed and unchecked.
- All of br_taken, mispredict and redirect_pc are combinational, with zero-cycle latency inside ID.
- BHT: 2^BHT_IDX_W entries of 2 bits each. States:
  - 00 strong-NT
  - 01 weak-NT
  - 10 weak-T
  - 11 strong-T
- Prediction: IF_pred_taken = bht[IF_pc idx][1]. This read is combinational.
- Update on the clock edge when resolve_en and funct3 is legal:
  - taken: saturating increment, 11 stays 11.
  - not-taken: saturating decrement, 00 stays 00.
  - Illegal funct3: no update.
- Simultaneous IF read and ID update to the same index: IF sees the pre-update value (no bypass). The updated value is visible the next cycle.
- stall=1: no BHT update; br_taken=0 and mispredict=0. The held branch resolves on the first non-stall cycle with fresh forwarding.
- ID_valid=0 or ID_is_branch=0: outputs 0; redirect_pc is still driven (don't-care to consumers).
- Reset:
  - Every BHT entry is set to 01 (weak-NT), so IF_pred_taken=0 for all PCs after reset.
  - Reset asserted mid-operation overrides any update in that cycle.
  - Combinational outputs follow their inputs during reset, but no update occurs.

Optional Feature:
- Macro: BRPRED_STATS_EN.
- Defined:
  - Adds outputs stat_branches[31:0] and stat_mispred[31:0], both registered and cleared by rst.
  - stat_branches increments on every resolve_en cycle; stat_mispred increments on every mispredict cycle.
  - Both wrap at 2^32 (0xFFFFFFFF+1 = 0).
  - Counting occurs even for illegal funct3.
- Undefined: no stat ports and no counter logic; all other behaviour is identical.

Test Plan:
- Reset, then IF_pc=0x40 -> IF_pred_taken=0. BEQ at ID_pc=0x40 with regfile 5,5, fwd 00/00, pred 0 -> br_taken=1, mispredict=1, redirect_pc=0x40+imm(0x10)=0x50. Next cycle bht[0] reads 10, so IF_pred_taken=1 for 0x40.
- Forwarding priority: BNE with rs1 regfile=7, EX_result=3, forward_c=11, rs2 forward_d=10, ME_result=3 -> compare 3 vs 3, br_taken=0. With pred 1 -> mispredict=1, redirect_pc=ID_pc+4.
- Saturation: 4 consecutive taken BLTU (op_a=1, op_b=0xFFFFFFFF) at the same idx -> counter sequence 01->10->11->11. Then 1 not-taken -> 10, and the prediction is still 1.
- Signed vs unsigned: op_a=0xFFFFFFFF, op_b=1. BLT -> taken; BLTU -> not taken; BGE -> not taken; BGEU -> taken.
- Stall: taken BEQ held 3 cycles with stall=1 -> mispredict=0 and BHT unchanged. The stall drops and the branch resolves on the 4th cycle -> exactly one update. With BRPRED_STATS_EN, stat_branches increments by 1.
- Same-index collision: ID update of idx 3 (01->10) in the same cycle IF_pc maps to idx 3 -> IF_pred_taken=0 that cycle, 1 the next. Assert rst during an update -> entry reads 01.
